// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU constants for the fetch stage: redirect encodings, reset PC, instruction-memory base.
// Also holds the branch-offset sign-extension helper used by the next-PC mux.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] PC_RESET_C = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_C  = 32'h0000_3000;

  // Word offset from a 16-bit branch field, sign-extended to a byte offset.
  function automatic logic signed [31:0] br_offset(input logic [15:0] imm16);
    logic signed [31:0] off;
    off = {{14{imm16[15]}}, imm16, 2'b00};
    return off;
  endfunction

endpackage

// File: rtl/if_fetch_stage_npc_calc.sv
// Combinational next-PC selection: sequential, taken branch, j/jal and jr targets.
// All arithmetic wraps modulo 2^32; stall gating is left to the PC register owner.
module if_fetch_stage_npc_calc
  import if_fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_imm26,
  input  logic [31:0] id_rs_data,
  output logic [31:0] npc
);

  logic [31:0]        seq_tgt;
  logic [31:0]        br_tgt;
  logic [31:0]        j_tgt;
  logic signed [31:0] br_off;

  assign br_off  = br_offset(id_imm16);
  assign seq_tgt = pc + 32'd4;
  assign br_tgt  = id_pc + 32'd4 + $unsigned(br_off);
  assign j_tgt   = {id_pc[31:28], id_imm26, 2'b00};

  // Branch not taken falls through to the sequential target.
  always_comb begin
    npc = seq_tgt;
    case (npc_sel)
      NPC_BR:  if (br_taken) npc = br_tgt;
      NPC_J:   npc = j_tgt;
      NPC_JR:  npc = id_rs_data;
      default: npc = seq_tgt;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, feeds IF/ID,
// and latches the first illegal fetch address in a sticky error.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_C,
  parameter logic [31:0] IM_BASE  = IM_BASE_C,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] ID_PC,
  input  logic [15:0] ID_Imm16,
  input  logic [25:0] ID_Imm26,
  input  logic [31:0] ID_RsData,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Instr,
  output logic        IF_WE,
  output logic        fetch_err,
  output logic [31:0] err_pc
);

  // 33-bit limit so a window touching the top of the address space cannot wrap.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc_p0;
  logic [31:0] npc;
  logic        addr_ok;
  logic        vld_p0;

  if_fetch_stage_npc_calc u_npc_calc (
    .pc         (pc_p0),
    .npc_sel    (npc_sel),
    .br_taken   (br_taken),
    .id_pc      (ID_PC),
    .id_imm16   (ID_Imm16),
    .id_imm26   (ID_Imm26),
    .id_rs_data (ID_RsData),
    .npc        (npc)
  );

  assign addr_ok = (pc_p0[1:0] == 2'b00) && (pc_p0 >= IM_BASE) &&
                   ({1'b0, pc_p0} < IM_END);
  assign vld_p0  = ~stall;

  // Stage p0 boundary: PC register and sticky error capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0     <= PC_RESET;
      fetch_err <= 1'b0;
      err_pc    <= '0;
    end else begin
      if (vld_p0) pc_p0 <= npc;
      if (!addr_ok && !fetch_err) begin
        fetch_err <= 1'b1;
        err_pc    <= pc_p0;
      end
    end
  end

  // An illegal fetch injects a NOP so downstream never sees stray data.
  assign i_inst_addr = pc_p0;
  assign IF_PC       = pc_p0;
  assign IF_Instr    = addr_ok ? i_inst_rdata : 32'h0;
  assign IF_WE       = vld_p0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a reference PC/error model pushes the
// expected post-edge state each cycle, which is popped and compared after the edge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] ID_PC;
  logic [15:0] ID_Imm16;
  logic [25:0] ID_Imm26;
  logic [31:0] ID_RsData;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instr;
  logic        IF_WE;
  logic        fetch_err;
  logic [31:0] err_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic        err;
    logic [31:0] epc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic        m_err;
  logic [31:0] m_epc;
  int          n_checks = 0;
  int          n_errors = 0;

  if_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .npc_sel      (npc_sel),
    .br_taken     (br_taken),
    .ID_PC        (ID_PC),
    .ID_Imm16     (ID_Imm16),
    .ID_Imm26     (ID_Imm26),
    .ID_RsData    (ID_RsData),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .IF_PC        (IF_PC),
    .IF_Instr     (IF_Instr),
    .IF_WE        (IF_WE),
    .fetch_err    (fetch_err),
    .err_pc       (err_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign i_inst_rdata = imem(i_inst_addr);

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a < 32'h7000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, predict and compare post-edge state.
  task automatic cyc(input logic st, input logic [1:0] sel, input logic bt,
                     input logic [31:0] idpc, input logic [15:0] i16,
                     input logic [25:0] i26, input logic [31:0] rs);
    exp_t        e;
    logic [31:0] nx;
    stall = st; npc_sel = sel; br_taken = bt;
    ID_PC = idpc; ID_Imm16 = i16; ID_Imm26 = i26; ID_RsData = rs;
    #1;
    chk("if_pc", IF_PC, m_pc);
    chk("if_we", {31'b0, IF_WE}, {31'b0, ~st});
    chk("if_instr", IF_Instr, legal(m_pc) ? imem(m_pc) : 32'h0);
    case (sel)
      2'b01:   nx = bt ? idpc + 32'd4 + {{14{i16[15]}}, i16, 2'b00} : m_pc + 32'd4;
      2'b10:   nx = {idpc[31:28], i26, 2'b00};
      2'b11:   nx = rs;
      default: nx = m_pc + 32'd4;
    endcase
    if (st) nx = m_pc;
    if (!legal(m_pc) && !m_err) begin
      m_err = 1'b1;
      m_epc = m_pc;
    end
    m_pc = nx;
    e.pc = m_pc; e.err = m_err; e.epc = m_epc;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("pc", i_inst_addr, e.pc);
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, e.err});
    chk("err_pc", err_pc, e.epc);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_pc", i_inst_addr, 32'h3000);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);
    chk("rst_epc", err_pc, 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_pc", i_inst_addr, 32'h3000);
    reset = 1'b1;
    m_pc = 32'h3000; m_err = 1'b0; m_epc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b1; npc_sel = 2'b00; br_taken = 1'b0;
    ID_PC = '0; ID_Imm16 = '0; ID_Imm26 = '0; ID_RsData = '0;
    #12;
    do_reset();

    // Sequential fetch
    cyc(0, 2'b00, 0, 0, 0, 0, 0); chk("seq1", i_inst_addr, 32'h3004);
    cyc(0, 2'b00, 0, 0, 0, 0, 0); chk("seq2", i_inst_addr, 32'h3008);
    cyc(0, 2'b00, 0, 0, 0, 0, 0); chk("seq3", i_inst_addr, 32'h300C);
    cyc(0, 2'b00, 0, 0, 0, 0, 0); chk("seq4", i_inst_addr, 32'h3010);

    // Stall with pending jump, then release
    cyc(1, 2'b10, 0, 32'h3020, 0, 26'h0000C40, 0); chk("stall1", i_inst_addr, 32'h3010);
    cyc(1, 2'b10, 0, 32'h3020, 0, 26'h0000C40, 0); chk("stall2", i_inst_addr, 32'h3010);
    cyc(0, 2'b10, 0, 32'h3020, 0, 26'h0000C40, 0); chk("jump", i_inst_addr, 32'h3100);

    // Branches
    cyc(0, 2'b01, 1, 32'h3020, 16'hFFFE, 0, 0); chk("br_back", i_inst_addr, 32'h301C);
    cyc(0, 2'b01, 0, 32'h3020, 16'hFFFE, 0, 0); chk("br_not", i_inst_addr, 32'h3020);
    cyc(0, 2'b01, 1, 32'h3020, 16'h0004, 0, 0); chk("br_fwd", i_inst_addr, 32'h3034);

    // Misaligned jr, sticky error
    cyc(0, 2'b11, 0, 0, 0, 0, 32'h3042); chk("jr_mis", i_inst_addr, 32'h3042);
    chk("jr_nop", IF_Instr, 32'h0);
    cyc(0, 2'b00, 0, 0, 0, 0, 0);
    chk("err_set", {31'b0, fetch_err}, 32'h1);
    chk("err_pc1", err_pc, 32'h3042);
    cyc(0, 2'b11, 0, 0, 0, 0, 32'h8000);
    cyc(0, 2'b00, 0, 0, 0, 0, 0);
    chk("err_sticky", err_pc, 32'h3042);

    // Out of range, wrap, reset recovery
    do_reset();
    cyc(0, 2'b11, 0, 0, 0, 0, 32'h6FFC);
    cyc(0, 2'b00, 0, 0, 0, 0, 0); chk("top_pc", i_inst_addr, 32'h7000);
    chk("top_nop", IF_Instr, 32'h0);
    chk("top_err_pre", {31'b0, fetch_err}, 32'h0);
    cyc(0, 2'b11, 0, 0, 0, 0, 32'hFFFF_FFFC);
    chk("top_err", {31'b0, fetch_err}, 32'h1);
    chk("top_epc", err_pc, 32'h7000);
    cyc(0, 2'b00, 0, 0, 0, 0, 0); chk("wrap", i_inst_addr, 32'h0000_0000);
    do_reset();

    // Randomised redirect mix
    for (int i = 0; i < 40; i++) begin
      logic        st;
      logic [1:0]  sel;
      logic [31:0] rs;
      st  = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      rs  = 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
      if ($urandom_range(0, 7) == 0) rs = rs | 32'h1;
      cyc(st, sel, 1'($urandom_range(0, 1)), m_pc - 32'd4,
          16'($urandom_range(0, 64)) - 16'd32,
          26'h0000C00 + 26'($urandom_range(0, 1023)), rs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS flow CPU; sits directly upstream of the IF/ID pipeline register.
- Owns the PC register and next-PC selection: sequential, branch, j/jal, jr. Redirect information comes from the ID stage.
- Drives the external instruction-memory address and presents {IF_PC, IF_Instr, IF_WE} to the IF/ID register.
- Flags illegal fetch addresses with a sticky error.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch byte address.
- IM_WORDS, 4096, number of legal instruction words starting at IM_BASE.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall request; freezes PC this cycle.
- npc_sel  in  2  redirect type from ID: 00 seq, 01 branch, 10 j/jal, 11 jr.
- br_taken  in  1  ID comparator result; qualifies npc_sel=01.
- ID_PC  in  32  PC of the instruction currently in ID.
- ID_Imm16  in  16  branch offset field of ID instruction.
- ID_Imm26  in  26  jump index field of ID instruction.
- ID_RsData  in  32  forwarded rs value for jr/jalr.
- i_inst_addr  out  32  instruction-memory byte address.
- i_inst_rdata  in  32  instruction-memory read data (combinational, same cycle).
- IF_PC  out  32  PC of fetched instruction, to IF/ID.
- IF_Instr  out  32  fetched instruction, to IF/ID.
- IF_WE  out  1  IF/ID write enable.
- fetch_err  out  1  sticky illegal-fetch flag.
- err_pc  out  32  PC of first illegal fetch.

Behaviour:
- State elements: PC (32), fetch_err (1), err_pc (32). No other storage.
- Reset:
  - reset low asynchronously forces PC=PC_RESET, fetch_err=0, err_pc=0, with no dependence on clk.
  - Release of reset takes effect at the next rising edge.
- Combinational outputs:
  - i_inst_addr = PC; IF_PC = PC; IF_WE = ~stall.
- Legality check:
  - addr_ok = (PC[1:0]==0) && (PC >= IM_BASE) && (PC < IM_BASE + 4*IM_WORDS).
  - IF_Instr = addr_ok ? i_inst_rdata : 32'h0, so an illegal fetch injects a NOP.
- Target arithmetic, all mod 2^32 with wrap and no overflow detection:
  - seq = PC + 4.
  - br = ID_PC + 4 + {{14{ID_Imm16[15]}}, ID_Imm16, 2'b00}.
  - j = {ID_PC[31:28], ID_Imm26, 2'b00}.
  - jr = ID_RsData, used unmodified (misalignment is caught by the legality check on the following fetch).
- Next-PC priority on each rising edge:
  1. stall=1: PC holds. Any redirect is ignored; ID re-presents it on the next unstalled cycle.
  2. npc_sel=01 and br_taken=1: PC <= br.
  3. npc_sel=10: PC <= j.
  4. npc_sel=11: PC <= jr.
  5. Otherwise, including npc_sel=01 with br_taken=0: PC <= seq.
- Delayed-branch semantics:
  - When a redirect is applied, IF already holds ID_PC+4 (the delay slot). The delay slot is passed to IF/ID normally.
  - No flush output exists; the delay slot always executes.
- Error capture:
  - On a rising edge with addr_ok=0 and fetch_err=0: fetch_err <= 1, err_pc <= PC.
  - Once set, both hold until reset; later illegal fetches do not overwrite err_pc.
  - Capture happens regardless of stall.
- Latency:
  - Redirect presented in cycle N becomes i_inst_addr in cycle N+1, given stall=0 in cycle N.

Decomposition:
- Shared CPU package (macro header in the codebase) holds:
  - NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11.
  - PC_RESET and IM_BASE constants.
- One natural sub-module: npc_calc, a purely combinational next-PC and target mux.
- PC register, legality check and error capture stay in if_fetch_stage.

Test Plan:
- Reset and sequential fetch: pulse reset low mid-cycle -> PC=0x3000 immediately. Release, npc_sel=00, stall=0 for 3 edges -> i_inst_addr 0x3004, 0x3008, 0x300C. IF_Instr equals i_inst_rdata; IF_WE=1.
- Stall with pending redirect: PC=0x3010, stall=1, npc_sel=10, Imm26=0x0000C40 for 2 edges -> PC stays 0x3010, IF_WE=0. Drop stall -> next PC 0x3100.
- Branch taken and not taken: ID_PC=0x3020, Imm16=0xFFFE.
  - br_taken=1 -> PC=0x301C.
  - br_taken=0 -> PC = current PC+4.
  - ID_PC=0x3020, Imm16=0x0004, br_taken=1 -> PC=0x3034.
- jr misaligned: npc_sel=11, ID_RsData=0x3042 -> PC=0x3042, IF_Instr=0. Next edge -> fetch_err=1, err_pc=0x3042. Subsequent jr to 0x8000 -> err_pc stays 0x3042.
- Out-of-range, wrap and reset recovery:
  - PC=0x6FFC sequential -> PC=0x7000, IF_Instr=0, fetch_err sets.
  - jr to 0xFFFF_FFFC then seq -> PC=0x0000_0000.
  - Assert reset -> fetch_err=0, err_pc=0, PC=0x3000.
